// File: rtl/mem_pkg.sv
// Shared constants and state type for the vector load/store front-end
// that sits upstream of mainMemory.
package mem_pkg;

  localparam int MEM_ADDR_W = 18;
  localparam int MEM_DATA_W = 24;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} vmu_state_t;

endpackage

// File: rtl/vector_mem_unit.sv
// Vector load/store front-end: accepts one LANES-wide request, issues it two
// lanes per beat on the dual memory ports, then returns a single response.
module vector_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LANES*DATA_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LANES*DATA_W-1:0]   resp_rdata,
  output logic [ADDR_W-1:0]         mem_address_a,
  output logic [ADDR_W-1:0]         mem_address_b,
  output logic [DATA_W-1:0]         mem_data_a,
  output logic [DATA_W-1:0]         mem_data_b,
  output logic                      mem_wren_a,
  output logic                      mem_wren_b,
  input  logic [DATA_W-1:0]         mem_q_a,
  input  logic [DATA_W-1:0]         mem_q_b
);

  localparam int BEATS  = LANES / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VEC_W  = LANES * DATA_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  vmu_state_t         r_state;
  logic               r_we;
  logic [BEAT_W-1:0]  r_beat;
  logic [VEC_W-1:0]   r_wdata;
  logic [VEC_W-1:0]   w_wdataNext;
  logic [VEC_W-1:0]   w_captureWide;

  assign req_ready = (r_state == IDLE);

  // Store lanes not yet issued sit at the bottom of r_wdata; each beat consumes two.
  assign w_wdataNext = r_wdata >> (2 * DATA_W);

  // Load data enters at the top lane pair and shifts down, so after the last
  // beat lane 0 holds the data captured first.
  assign w_captureWide = VEC_W'({mem_q_b, mem_q_a}) << ((LANES - 2) * DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_beat        <= '0;
      r_wdata       <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_address_a <= '0;
      mem_address_b <= '0;
      mem_data_a    <= '0;
      mem_data_b    <= '0;
      mem_wren_a    <= 1'b0;
      mem_wren_b    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state       <= BEAT;
            r_we          <= req_we;
            r_beat        <= '0;
            r_wdata       <= req_wdata >> (2 * DATA_W);
            mem_address_a <= req_addr;
            mem_address_b <= req_addr + ADDR_W'(1);
            mem_data_a    <= req_we ? req_wdata[0 +: DATA_W] : '0;
            mem_data_b    <= req_we ? req_wdata[DATA_W +: DATA_W] : '0;
            mem_wren_a    <= req_we;
            mem_wren_b    <= req_we;
          end
        end

        BEAT: begin
          if (!r_we) begin
            resp_rdata <= (resp_rdata >> (2 * DATA_W)) | w_captureWide;
          end
          if (r_beat == LAST_BEAT) begin
            r_state       <= RESP;
            resp_valid    <= 1'b1;
            mem_address_a <= '0;
            mem_address_b <= '0;
            mem_data_a    <= '0;
            mem_data_b    <= '0;
            mem_wren_a    <= 1'b0;
            mem_wren_b    <= 1'b0;
          end else begin
            // Address arithmetic wraps naturally at the ADDR_W boundary.
            r_beat        <= r_beat + 1'b1;
            r_wdata       <= w_wdataNext;
            mem_address_a <= mem_address_a + ADDR_W'(2);
            mem_address_b <= mem_address_a + ADDR_W'(3);
            mem_data_a    <= r_we ? r_wdata[0 +: DATA_W] : '0;
            mem_data_b    <= r_we ? r_wdata[DATA_W +: DATA_W] : '0;
          end
        end

        RESP: begin
          if (resp_ready) begin
            r_state    <= IDLE;
            resp_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
